// File: rtl/hypervisor_ctrl.sv
// Hypervisor control register window ($D640-$D67F): traps user-mode writes,
// serves as a state register file in hypervisor mode, and streams saved user state on exit.
module hypervisor_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       hyper_cs,
    input  logic [7:0] hyper_addr,
    input  logic [7:0] hyper_io_data_i,
    input  logic       cpu_write,
    input  logic       ready,
    input  logic       hyper_mode,
    input  logic       load_user_reg,
    output logic [7:0] hyper_data_o,
    output logic       hyp,
    output logic [7:0] user_mapper_reg
);

    logic [7:0] r_regfile [0:61];
    logic [5:0] r_trapnum;
    logic [5:0] r_ridx;
    logic       r_hyp;
    logic [7:0] r_data;
    logic [7:0] r_umr;

    logic [5:0] w_off;
    logic       w_wr;
    logic       w_rd;
    logic [7:0] w_rd_val;
    logic [7:0] w_umr_val;
    logic [5:0] w_ridx_nxt;
    logic       w_unused;

    assign w_off    = hyper_addr[5:0];
    assign w_wr     = hyper_cs & cpu_write & ready;
    // Reads deliberately ignore ready: they have no side effects.
    assign w_rd     = hyper_cs & ~cpu_write;
    assign w_unused = ^hyper_addr[7:6];

    assign hyper_data_o    = r_data;
    assign hyp             = r_hyp;
    assign user_mapper_reg = r_umr;

    // Read-data selection; user mode sees an all-ones window.
    always_comb begin
        w_rd_val = 8'hFF;
        if (!hyper_mode) begin
            w_rd_val = 8'hFF;
        end else if (w_off <= 6'd61) begin
            w_rd_val = r_regfile[w_off];
        end else if (w_off == 6'd62) begin
            w_rd_val = {2'b00, r_trapnum};
        end else begin
            w_rd_val = {7'b0000000, hyper_mode};
        end
    end

    // Restore-stream byte and saturating index advance.
    always_comb begin
        w_umr_val  = 8'h00;
        w_ridx_nxt = r_ridx;
        if (r_ridx <= 6'd61) begin
            w_umr_val = r_regfile[r_ridx];
        end else begin
            w_umr_val = 8'h00;
        end
        if (!load_user_reg) begin
            w_ridx_nxt = 6'd0;
        end else if (!ready) begin
            w_ridx_nxt = r_ridx;
        end else if (r_ridx == 6'd63) begin
            w_ridx_nxt = 6'd63;
        end else begin
            w_ridx_nxt = r_ridx + 6'd1;
        end
    end

    // Register file: written only from hypervisor mode, top two offsets are not storage.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 62; i++) begin
                r_regfile[i] <= 8'h00;
            end
        end else if (w_wr && hyper_mode && (w_off <= 6'd61)) begin
            r_regfile[w_off] <= hyper_io_data_i;
        end
    end

    // Trap request: first user-mode write wins, cleared on entry to hypervisor mode.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hyp     <= 1'b0;
            r_trapnum <= 6'd0;
        end else if (hyper_mode) begin
            r_hyp <= 1'b0;
        end else if (w_wr && !r_hyp) begin
            r_hyp     <= 1'b1;
            r_trapnum <= w_off;
        end
    end

    // Registered read data and restore stream.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data <= 8'h00;
            r_umr  <= 8'h00;
            r_ridx <= 6'd0;
        end else begin
            if (w_rd) begin
                r_data <= w_rd_val;
            end
            r_umr  <= w_umr_val;
            r_ridx <= w_ridx_nxt;
        end
    end

endmodule

// File: tb/tb_hypervisor_ctrl.sv
// Scoreboard bench for hypervisor_ctrl: directed scenarios plus randomized traffic
// against a behavioural model of the register window.
module tb_hypervisor_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       hyper_cs;
    logic [7:0] hyper_addr;
    logic [7:0] hyper_io_data_i;
    logic       cpu_write;
    logic       ready;
    logic       hyper_mode;
    logic       load_user_reg;
    logic [7:0] hyper_data_o;
    logic       hyp;
    logic [7:0] user_mapper_reg;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [7:0] hdo;
        logic       hyp;
        logic [7:0] umr;
    } exp_t;
    exp_t exp_q[$];

    logic [7:0] m_rf [0:61];
    logic [5:0] m_trap;
    logic       m_hyp;
    int         m_ridx;
    logic [7:0] m_hdo;
    logic [7:0] m_umr;

    hypervisor_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .hyper_cs        (hyper_cs),
        .hyper_addr      (hyper_addr),
        .hyper_io_data_i (hyper_io_data_i),
        .cpu_write       (cpu_write),
        .ready           (ready),
        .hyper_mode      (hyper_mode),
        .load_user_reg   (load_user_reg),
        .hyper_data_o    (hyper_data_o),
        .hyp             (hyp),
        .user_mapper_reg (user_mapper_reg)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%02h expected=%02h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 62; i++) m_rf[i] = 8'h00;
        m_trap = 6'd0;
        m_hyp  = 1'b0;
        m_ridx = 0;
        m_hdo  = 8'h00;
        m_umr  = 8'h00;
    endtask

    // Drive one bus cycle, apply the edge to the model, queue the expected outputs.
    task automatic cycle(input logic cs, input logic [7:0] addr, input logic [7:0] data,
                         input logic we, input logic rdy, input logic hm, input logic lur);
        int   off;
        exp_t e;
        hyper_cs = cs; hyper_addr = addr; hyper_io_data_i = data;
        cpu_write = we; ready = rdy; hyper_mode = hm; load_user_reg = lur;
        @(posedge clk);
        off = int'(addr[5:0]);
        if (cs && !we) begin
            if (!hm)            m_hdo = 8'hFF;
            else if (off < 62)  m_hdo = m_rf[off];
            else if (off == 62) m_hdo = {2'b00, m_trap};
            else                m_hdo = 8'h01;
        end
        m_umr = (m_ridx < 62) ? m_rf[m_ridx] : 8'h00;
        if (hm) m_hyp = 1'b0;
        else if (cs && we && rdy && !m_hyp) begin
            m_hyp  = 1'b1;
            m_trap = addr[5:0];
        end
        if (cs && we && rdy && hm && off < 62) m_rf[off] = data;
        if (!lur)     m_ridx = 0;
        else if (rdy) m_ridx = (m_ridx + 1 > 63) ? 63 : m_ridx + 1;
        e.hdo = m_hdo; e.hyp = m_hyp; e.umr = m_umr;
        exp_q.push_back(e);
        #1;
    endtask

    task automatic mid_reset();
        @(negedge clk);
        #1;
        reset = 1'b0;
        #1;
        check("rst_hyp", {7'b0, hyp}, 8'h00);
        check("rst_hdo", hyper_data_o, 8'h00);
        check("rst_umr", user_mapper_reg, 8'h00);
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        reset = 1'b1;
    endtask

    // Monitor: every edge presents fresh outputs; compare against the oldest expectation.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("sb_hdo", hyper_data_o, e.hdo);
            check("sb_hyp", {7'b0, hyp}, {7'b0, e.hyp});
            check("sb_umr", user_mapper_reg, e.umr);
        end
    end

    initial begin
        logic hm_r, lur_r;
        reset = 1'b0;
        hyper_cs = 1'b0; hyper_addr = 8'h00; hyper_io_data_i = 8'h00;
        cpu_write = 1'b0; ready = 1'b0; hyper_mode = 1'b0; load_user_reg = 1'b0;
        model_reset();
        #12;
        check("por_hyp", {7'b0, hyp}, 8'h00);
        check("por_hdo", hyper_data_o, 8'h00);
        check("por_umr", user_mapper_reg, 8'h00);
        reset = 1'b1;

        // User write traps; a second trap does not overwrite the first.
        cycle(1'b1, 8'h45, 8'h5A, 1'b1, 1'b1, 1'b0, 1'b0);
        check("t1_hyp", {7'b0, hyp}, 8'h01);
        cycle(1'b1, 8'h50, 8'h77, 1'b1, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 8'h7E, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        check("t1_trapnum", hyper_data_o, 8'h05);
        check("t2_hyp_clr", {7'b0, hyp}, 8'h00);
        cycle(1'b1, 8'h45, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        check("t1_rf_unchanged", hyper_data_o, 8'h00);

        // Hypervisor writes respect ready.
        cycle(1'b1, 8'h42, 8'hA5, 1'b1, 1'b0, 1'b1, 1'b0);
        cycle(1'b1, 8'h42, 8'h3C, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 8'h42, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        check("t3_read", hyper_data_o, 8'h3C);
        cycle(1'b1, 8'h42, 8'h00, 1'b0, 1'b1, 1'b0, 1'b0);
        check("t4_user_read", hyper_data_o, 8'hFF);
        cycle(1'b1, 8'h7F, 8'h00, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t4_mode_read", hyper_data_o, 8'h01);

        // Restore stream with a stalled ready.
        cycle(1'b1, 8'h40, 8'h11, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 8'h41, 8'h22, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 8'h42, 8'h33, 1'b1, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
        check("t5_umr0", user_mapper_reg, 8'h11);
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1, 1'b1);
        check("t5_umr1", user_mapper_reg, 8'h22);
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
        check("t5_umr2", user_mapper_reg, 8'h22);
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
        check("t5_umr3", user_mapper_reg, 8'h33);
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0);
        check("t5_rewind", user_mapper_reg, 8'h11);

        // Index saturation past the end of the register file.
        repeat (70) cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1, 1'b1);
        check("sat_umr", user_mapper_reg, 8'h00);

        // Reset in the middle of a stream with a pending trap.
        cycle(1'b1, 8'h4A, 8'h99, 1'b1, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1);
        check("t6_pre_hyp", {7'b0, hyp}, 8'h01);
        mid_reset();

        // Randomized traffic with slowly changing mode and restore phases.
        hm_r = 1'b1;
        lur_r = 1'b0;
        for (int n = 0; n < 2000; n++) begin
            if ($urandom_range(0, 15) == 0) hm_r = ~hm_r;
            if ($urandom_range(0, 19) == 0) lur_r = ~lur_r;
            cycle(($urandom_range(0, 3) != 0), 8'($urandom), 8'($urandom),
                  1'($urandom), ($urandom_range(0, 4) != 0), hm_r, lur_r);
            if (n % 700 == 699) mid_reset();
        end

        @(negedge clk);
        #1;
        check("queue_drained", 8'(exp_q.size()), 8'h00);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
